split_resume_arbiter: RTL and testbench
=======================================

// Module: split_resume_arbiter
// PURPOSE
//  Central scheduler for split read transactions on the serial bus. Records which master
//  owns each outstanding split (target_split_ack) and arbitrates resume requests
//  (split_req) from N split targets round-robin, one at a time, only while the bus is free.
//  Drives each target's split_grant and tells the bus mux which master gets the resumed data.
// PARAMETERS
//  N_TGT    3   number of split-capable targets (>=1)
//  MID_W    2   master ID width
//  TIMEOUT  16  cycles allowed after a grant for target_ack before abort (>=1)
// PORTS
//  clk            in   1        clock, rising edge
//  rst_n          in   1        asynchronous reset, active-low
//  split_ack      in   N_TGT    per-target target_split_ack pulse: split accepted
//  master_id      in   MID_W    ID of the master owning the bus in the current cycle
//  split_req      in   N_TGT    per-target resume request (level)
//  tgt_ack        in   N_TGT    per-target target_ack (resumed data valid)
//  bus_busy       in   1        normal master transfer in progress; blocks new grants
//  split_grant    out  N_TGT    one-hot grant pulse to the selected target
//  resume_active  out  1        bus reserved for a resume (GRANT or WAIT_DATA state)
//  resume_tgt     out  clog2(N_TGT) (min 1)  index of the target being resumed
//  resume_master  out  MID_W    master ID the resumed data is routed to
//  resume_done    out  1        1-cycle pulse: resume completed normally
//  timeout_err    out  1        1-cycle pulse: resume aborted on timeout
//  dup_split_err  out  1        1-cycle pulse: split_ack for a target already pending
// BEHAVIOUR
//  Reset: all outputs 0; pend_valid[] = 0; pend_mid[] = 0; rr_ptr = 0; state = IDLE; cnt = 0.
//  Pending table: split_ack[i] sets pend_valid[i] and pend_mid[i] <= master_id. If
//   pend_valid[i] is already 1: overwrite pend_mid[i] and pulse dup_split_err.
//  Eligible vector: elig = split_req & pend_valid. A request from a non-pending target is
//   never granted and is silently held off.
//  FSM (registered outputs):
//   IDLE: if elig != 0 and !bus_busy, pick the first set bit at or after rr_ptr (wrapping
//     N_TGT-1 -> 0). Latch idx, resume_tgt = idx, resume_master = pend_mid[idx].
//     Go to GRANT. split_grant[idx] = 1 and resume_active = 1 during the next cycle.
//     Result: elig seen in cycle t -> grant visible in cycle t+1.
//   GRANT (1 cycle): split_grant one-hot for exactly this cycle. Set cnt = TIMEOUT-1.
//     rr_ptr = idx+1 (mod N_TGT). Go to WAIT_DATA.
//   WAIT_DATA: hold split_grant = 0, resume_active = 1, and resume_tgt/master stable.
//     - tgt_ack[idx] seen (also accepted if it arrives in the GRANT cycle): pulse resume_done
//       next cycle, clear pend_valid[idx], go to IDLE.
//     - else if cnt == 0: pulse timeout_err, clear pend_valid[idx], go to IDLE.
//     - else cnt--.
//     - tgt_ack from any other target is ignored.
//  resume_active drops in the cycle after completion. A new grant may start in that same
//   cycle: IDLE evaluates immediately, so back-to-back resumes are 1 idle cycle apart.
//  bus_busy is sampled only in IDLE. An active resume is never preempted.
//  Same cycle clear(idx) and split_ack[idx]: the set wins (new split recorded, no dup error).
//  Counter width clog2(TIMEOUT+1). rr_ptr width is the same as resume_tgt.
//  Asynchronous reset mid-resume aborts at once: table cleared, no done/err pulse.
// TESTING
//  1 Reset: hold rst_n=0 -> all outputs 0. Release -> stays IDLE with split_req=0.
//  2 split_ack[1] with master_id=2, then split_req[1]=1, bus_busy=0 at cycle t
//    -> split_grant=3'b010 at t+1 only, resume_master=2, resume_tgt=1.
//    -> tgt_ack[1] at t+2 -> resume_done at t+3, pend_valid[1] cleared.
//  3 Targets 0 and 2 pending, both requesting, rr_ptr=0 -> grant 0 first, then 2.
//    Re-arm target 0 -> next grant goes to 2 before 0 (round-robin).
//  4 split_req[0]=1 with pend_valid[0]=0 -> no grant for 20 cycles.
//    bus_busy=1 with an eligible request -> no grant until bus_busy falls.
//  5 Grant issued, no tgt_ack for TIMEOUT=16 cycles -> timeout_err pulses once, slot cleared,
//    resume_active=0 after.
//  6 split_ack[2] twice without a resume -> dup_split_err pulse, pend_mid[2] = latest ID.
//    Assert rst_n=0 during WAIT_DATA -> immediate idle, no pulses.

Source files
------------

// File: rtl/split_resume_arbiter.sv
// Split-transaction resume scheduler: records the owning master of each outstanding split
// and grants resume requests round-robin, one at a time, while the bus is free.
module split_resume_arbiter #(
    parameter int unsigned N_TGT   = 3,
    parameter int unsigned MID_W   = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_TGT-1:0]                      split_ack,
    input  logic [MID_W-1:0]                      master_id,
    input  logic [N_TGT-1:0]                      split_req,
    input  logic [N_TGT-1:0]                      tgt_ack,
    input  logic                                  bus_busy,
    output logic [N_TGT-1:0]                      split_grant,
    output logic                                  resume_active,
    output logic [((N_TGT > 1) ? $clog2(N_TGT) : 1)-1:0] resume_tgt,
    output logic [MID_W-1:0]                      resume_master,
    output logic                                  resume_done,
    output logic                                  timeout_err,
    output logic                                  dup_split_err
);

    localparam int unsigned TGT_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TGT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TGT_W-1:0]   tgt_q, tgt_d;
    logic [MID_W-1:0]   master_q, master_d;
    logic [N_TGT-1:0]   grant_q, grant_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               tout_q, tout_d;
    logic               dup_q, dup_d;
    logic [N_TGT-1:0]   pend_valid_q, pend_valid_d;
    logic [MID_W-1:0]   pend_mid_q [N_TGT];
    logic [MID_W-1:0]   pend_mid_d [N_TGT];

    logic [N_TGT-1:0]   elig;
    logic [N_TGT-1:0]   clr;
    logic [TGT_W:0]     sum;
    logic [TGT_W-1:0]   cand;
    logic [TGT_W-1:0]   pick;
    logic               found;

    assign elig = split_req & pend_valid_q;

    // Round-robin search starting at rr_ptr, wrapping N_TGT-1 -> 0
    always_comb begin
        sum   = '0;
        cand  = '0;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_TGT; k++) begin
            sum = {1'b0, rr_ptr_q} + (TGT_W+1)'(k);
            if (sum >= (TGT_W+1)'(N_TGT)) begin
                sum = sum - (TGT_W+1)'(N_TGT);
            end
            cand = sum[TGT_W-1:0];
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        tgt_d        = tgt_q;
        master_d     = master_q;
        grant_d      = '0;
        active_d     = active_q;
        done_d       = 1'b0;
        tout_d       = 1'b0;
        dup_d        = 1'b0;
        clr          = '0;
        pend_valid_d = pend_valid_q;
        pend_mid_d   = pend_mid_q;

        unique case (state_q)
            S_IDLE: begin
                if (found && !bus_busy) begin
                    state_d  = S_GRANT;
                    grant_d  = N_TGT'(1) << pick;
                    active_d = 1'b1;
                    tgt_d    = pick;
                    master_d = pend_mid_q[pick];
                end
            end
            S_GRANT: begin
                cnt_d    = CNT_W'(TIMEOUT - 1);
                rr_ptr_d = (tgt_q == TGT_W'(N_TGT - 1)) ? '0 : tgt_q + 1'b1;
                if (tgt_ack[tgt_q]) begin
                    done_d      = 1'b1;
                    active_d    = 1'b0;
                    clr[tgt_q]  = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (tgt_ack[tgt_q]) begin
                    done_d     = 1'b1;
                    active_d   = 1'b0;
                    clr[tgt_q] = 1'b1;
                    state_d    = S_IDLE;
                end else if (cnt_q == '0) begin
                    tout_d     = 1'b1;
                    active_d   = 1'b0;
                    clr[tgt_q] = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase

        // A new split in the same cycle as its slot is released wins and is not a duplicate
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (clr[i]) begin
                pend_valid_d[i] = 1'b0;
            end
            if (split_ack[i]) begin
                if (pend_valid_q[i] && !clr[i]) begin
                    dup_d = 1'b1;
                end
                pend_valid_d[i] = 1'b1;
                pend_mid_d[i]   = master_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            tgt_q        <= '0;
            master_q     <= '0;
            grant_q      <= '0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            tout_q       <= 1'b0;
            dup_q        <= 1'b0;
            pend_valid_q <= '0;
            pend_mid_q   <= '{default: '0};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            tgt_q        <= tgt_d;
            master_q     <= master_d;
            grant_q      <= grant_d;
            active_q     <= active_d;
            done_q       <= done_d;
            tout_q       <= tout_d;
            dup_q        <= dup_d;
            pend_valid_q <= pend_valid_d;
            pend_mid_q   <= pend_mid_d;
        end
    end

    assign split_grant   = grant_q;
    assign resume_active = active_q;
    assign resume_tgt    = tgt_q;
    assign resume_master = master_q;
    assign resume_done   = done_q;
    assign timeout_err   = tout_q;
    assign dup_split_err = dup_q;

endmodule

// File: tb/tb_split_resume_arbiter.sv
// Bench for split_resume_arbiter: cycle vectors plus hand-written corner sequences,
// expected outputs queued when stimulus is driven and compared one cycle later.
module tb_split_resume_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] split_ack;
    logic [1:0] master_id;
    logic [2:0] split_req;
    logic [2:0] tgt_ack;
    logic       bus_busy;
    logic [2:0] split_grant;
    logic       resume_active;
    logic [1:0] resume_tgt;
    logic [1:0] resume_master;
    logic       resume_done;
    logic       timeout_err;
    logic       dup_split_err;

    split_resume_arbiter #(.N_TGT(3), .MID_W(2), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .split_ack     (split_ack),
        .master_id     (master_id),
        .split_req     (split_req),
        .tgt_ack       (tgt_ack),
        .bus_busy      (bus_busy),
        .split_grant   (split_grant),
        .resume_active (resume_active),
        .resume_tgt    (resume_tgt),
        .resume_master (resume_master),
        .resume_done   (resume_done),
        .timeout_err   (timeout_err),
        .dup_split_err (dup_split_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] grant;
        logic       act;
        logic [1:0] tgt;
        logic [1:0] mst;
        logic       done;
        logic       tout;
        logic       dup;
    } out_t;

    typedef struct {
        string      name;
        logic [2:0] sack;
        logic [1:0] mid;
        logic [2:0] req;
        logic [2:0] ack;
        logic       busy;
        out_t       exp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    function automatic out_t mk(logic [2:0] g, logic a, logic [1:0] t, logic [1:0] m,
                                logic d, logic to, logic du);
        out_t o;
        o.grant = g; o.act = a; o.tgt = t; o.mst = m;
        o.done = d; o.tout = to; o.dup = du;
        return o;
    endfunction

    function automatic out_t idle(logic [1:0] t, logic [1:0] m);
        return mk(3'b000, 1'b0, t, m, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t mv(string n, logic [2:0] sa, logic [1:0] mi, logic [2:0] rq,
                                logic [2:0] ak, logic bb, out_t e);
        vec_t v;
        v.name = n; v.sack = sa; v.mid = mi; v.req = rq; v.ack = ak; v.busy = bb; v.exp = e;
        return v;
    endfunction

    function automatic out_t actual();
        return mk(split_grant, resume_active, resume_tgt, resume_master,
                  resume_done, timeout_err, dup_split_err);
    endfunction

    task automatic check(input string name);
        out_t e, a;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            e = exp_q.pop_front();
            a = actual();
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got grant=%b act=%b tgt=%0d mst=%0d done=%b tout=%b dup=%b, want grant=%b act=%b tgt=%0d mst=%0d done=%b tout=%b dup=%b",
                         name, a.grant, a.act, a.tgt, a.mst, a.done, a.tout, a.dup,
                         e.grant, e.act, e.tgt, e.mst, e.done, e.tout, e.dup);
            end
        end
    endtask

    task automatic step(input vec_t v);
        split_ack = v.sack;
        master_id = v.mid;
        split_req = v.req;
        tgt_ack   = v.ack;
        bus_busy  = v.busy;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        check(v.name);
    endtask

    task automatic do_reset();
        split_ack = '0; master_id = '0; split_req = '0; tgt_ack = '0; bus_busy = 1'b0;
        rst_n = 1'b0;
        #2;
        exp_q.push_back(idle(2'd0, 2'd0));
        check("reset_async");
        repeat (2) step(mv("reset_hold", 3'b000, 2'd0, 3'b000, 3'b000, 1'b0, idle(2'd0, 2'd0)));
        rst_n = 1'b1;
        repeat (2) step(mv("reset_release", 3'b000, 2'd0, 3'b000, 3'b000, 1'b0, idle(2'd0, 2'd0)));
    endtask

    initial begin
        // Basic resume of target 1 on behalf of master 2
        vecs.push_back(mv("t2_split",   3'b010, 2'd2, 3'b000, 3'b000, 1'b0, idle(2'd0, 2'd0)));
        vecs.push_back(mv("t2_grant",   3'b000, 2'd0, 3'b010, 3'b000, 1'b0, mk(3'b010, 1, 2'd1, 2'd2, 0, 0, 0)));
        vecs.push_back(mv("t2_gcycle",  3'b000, 2'd0, 3'b010, 3'b000, 1'b0, mk(3'b000, 1, 2'd1, 2'd2, 0, 0, 0)));
        vecs.push_back(mv("t2_done",    3'b000, 2'd0, 3'b010, 3'b010, 1'b0, mk(3'b000, 0, 2'd1, 2'd2, 1, 0, 0)));
        vecs.push_back(mv("t2_cleared", 3'b000, 2'd0, 3'b010, 3'b000, 1'b0, idle(2'd1, 2'd2)));
        vecs.push_back(mv("t2_idle",    3'b000, 2'd0, 3'b000, 3'b000, 1'b0, idle(2'd1, 2'd2)));
        // Round-robin between targets 0 and 2, target 0 re-armed as it completes
        vecs.push_back(mv("t3_rst_sep", 3'b000, 2'd0, 3'b000, 3'b000, 1'b0, idle(2'd1, 2'd2)));
    end

    initial begin
        vec_t rr[$];
        rr.push_back(mv("t3_split0",  3'b001, 2'd1, 3'b000, 3'b000, 1'b0, idle(2'd0, 2'd0)));
        rr.push_back(mv("t3_split2",  3'b100, 2'd3, 3'b000, 3'b000, 1'b0, idle(2'd0, 2'd0)));
        rr.push_back(mv("t3_grant0",  3'b000, 2'd0, 3'b101, 3'b000, 1'b0, mk(3'b001, 1, 2'd0, 2'd1, 0, 0, 0)));
        rr.push_back(mv("t3_gcyc0",   3'b000, 2'd0, 3'b101, 3'b000, 1'b0, mk(3'b000, 1, 2'd0, 2'd1, 0, 0, 0)));
        rr.push_back(mv("t3_done0_rearm", 3'b001, 2'd2, 3'b101, 3'b001, 1'b0, mk(3'b000, 0, 2'd0, 2'd1, 1, 0, 0)));
        rr.push_back(mv("t3_grant2",  3'b000, 2'd0, 3'b101, 3'b000, 1'b0, mk(3'b100, 1, 2'd2, 2'd3, 0, 0, 0)));
        rr.push_back(mv("t3_gcyc2",   3'b000, 2'd0, 3'b101, 3'b000, 1'b0, mk(3'b000, 1, 2'd2, 2'd3, 0, 0, 0)));
        rr.push_back(mv("t3_other_ack", 3'b000, 2'd0, 3'b101, 3'b001, 1'b0, mk(3'b000, 1, 2'd2, 2'd3, 0, 0, 0)));
        rr.push_back(mv("t3_done2",   3'b000, 2'd0, 3'b101, 3'b100, 1'b0, mk(3'b000, 0, 2'd2, 2'd3, 1, 0, 0)));
        rr.push_back(mv("t3_regrant0", 3'b000, 2'd0, 3'b101, 3'b000, 1'b0, mk(3'b001, 1, 2'd0, 2'd2, 0, 0, 0)));
        rr.push_back(mv("t3_gcyc0b",  3'b000, 2'd0, 3'b000, 3'b000, 1'b0, mk(3'b000, 1, 2'd0, 2'd2, 0, 0, 0)));
        rr.push_back(mv("t3_done0b",  3'b000, 2'd0, 3'b000, 3'b001, 1'b0, mk(3'b000, 0, 2'd0, 2'd2, 1, 0, 0)));
        rr.push_back(mv("t3_idle",    3'b000, 2'd0, 3'b000, 3'b000, 1'b0, idle(2'd0, 2'd2)));

        rst_n = 1'b0;
        #1;
        do_reset();

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        do_reset();
        for (int i = 0; i < rr.size(); i++) step(rr[i]);

        // Request from a non-pending target is never granted
        for (int i = 0; i < 20; i++)
            step(mv("t4_not_pending", 3'b000, 2'd0, 3'b001, 3'b000, 1'b0, idle(2'd0, 2'd2)));
        step(mv("t4_split1", 3'b010, 2'd3, 3'b001, 3'b000, 1'b0, idle(2'd0, 2'd2)));
        for (int i = 0; i < 5; i++)
            step(mv("t4_busy_hold", 3'b000, 2'd0, 3'b010, 3'b000, 1'b1, idle(2'd0, 2'd2)));
        step(mv("t4_busy_fall", 3'b000, 2'd0, 3'b010, 3'b000, 1'b0, mk(3'b010, 1, 2'd1, 2'd3, 0, 0, 0)));
        step(mv("t4_gcyc_busy", 3'b000, 2'd0, 3'b010, 3'b000, 1'b1, mk(3'b000, 1, 2'd1, 2'd3, 0, 0, 0)));
        step(mv("t4_done",      3'b000, 2'd0, 3'b010, 3'b010, 1'b1, mk(3'b000, 0, 2'd1, 2'd3, 1, 0, 0)));
        step(mv("t4_idle",      3'b000, 2'd0, 3'b000, 3'b000, 1'b0, idle(2'd1, 2'd3)));

        // Timeout: 16 waiting cycles after the grant cycle, then one error pulse
        step(mv("t5_split2", 3'b100, 2'd1, 3'b000, 3'b000, 1'b0, idle(2'd1, 2'd3)));
        step(mv("t5_grant",  3'b000, 2'd0, 3'b100, 3'b000, 1'b0, mk(3'b100, 1, 2'd2, 2'd1, 0, 0, 0)));
        step(mv("t5_gcyc",   3'b000, 2'd0, 3'b100, 3'b000, 1'b0, mk(3'b000, 1, 2'd2, 2'd1, 0, 0, 0)));
        for (int i = 0; i < 15; i++)
            step(mv("t5_wait", 3'b000, 2'd0, 3'b100, 3'b000, 1'b0, mk(3'b000, 1, 2'd2, 2'd1, 0, 0, 0)));
        step(mv("t5_timeout", 3'b000, 2'd0, 3'b100, 3'b000, 1'b0, mk(3'b000, 0, 2'd2, 2'd1, 0, 1, 0)));
        step(mv("t5_after",   3'b000, 2'd0, 3'b100, 3'b000, 1'b0, idle(2'd2, 2'd1)));
        step(mv("t5_after2",  3'b000, 2'd0, 3'b100, 3'b100, 1'b0, idle(2'd2, 2'd1)));

        // Duplicate split keeps the latest master ID
        step(mv("t6_split_a", 3'b100, 2'd1, 3'b000, 3'b000, 1'b0, idle(2'd2, 2'd1)));
        step(mv("t6_split_b", 3'b100, 2'd2, 3'b000, 3'b000, 1'b0, mk(3'b000, 0, 2'd2, 2'd1, 0, 0, 1)));
        step(mv("t6_dup_once", 3'b000, 2'd0, 3'b000, 3'b000, 1'b0, idle(2'd2, 2'd1)));
        step(mv("t6_grant",   3'b000, 2'd0, 3'b100, 3'b000, 1'b0, mk(3'b100, 1, 2'd2, 2'd2, 0, 0, 0)));
        step(mv("t6_gcyc",    3'b000, 2'd0, 3'b100, 3'b000, 1'b0, mk(3'b000, 1, 2'd2, 2'd2, 0, 0, 0)));
        step(mv("t6_wait",    3'b000, 2'd0, 3'b100, 3'b000, 1'b0, mk(3'b000, 1, 2'd2, 2'd2, 0, 0, 0)));

        // Asynchronous reset in the middle of WAIT_DATA
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(idle(2'd0, 2'd0));
        check("t6_async_abort");
        for (int i = 0; i < 3; i++)
            step(mv("t6_rst_hold", 3'b000, 2'd0, 3'b100, 3'b100, 1'b0, idle(2'd0, 2'd0)));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step(mv("t6_table_cleared", 3'b000, 2'd0, 3'b100, 3'b100, 1'b0, idle(2'd0, 2'd0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
